hazard_controller: RTL and testbench

HAZARD_CONTROLLER -- requirements
Module: hazard_controller

---
 rtl/hazard_controller.sv | 143 ++++++++++++++
 tb/tb_hazard_controller.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_controller.sv
// Pipeline hazard controller: operand forwarding, load-use / branch / memory-wait
// stall and flush control, memory timeout detection and saturating performance counters.
module hazard_controller #(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       RS1_D,
   input  logic [4:0]       RS2_D,
   input  logic [4:0]       RS1_E,
   input  logic [4:0]       RS2_E,
   input  logic [4:0]       RD_E,
   input  logic             MEM_REG_E,
   input  logic [4:0]       RD_M,
   input  logic             WE_M,
   input  logic [4:0]       RD_W,
   input  logic             WE_W,
   input  logic             PC_R,
   input  logic             MEM_REQ,
   input  logic             MEM_ACK,
   input  logic             CNT_CLR,
   output logic [1:0]       HU_RS1,
   output logic [1:0]       HU_RS2,
   output logic             STALL_F,
   output logic             STALL_D,
   output logic             STALL_E,
   output logic             STALL_M,
   output logic             FLUSH_D,
   output logic             FLUSH_E,
   output logic             ERR,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   localparam int unsigned WCNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
   localparam logic [WCNT_W-1:0] TIMEOUT_V = WCNT_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      WAIT  = 2'd1,
      ERROR = 2'd2
   } state_t;

   state_t            state, state_nxt;
   logic [WCNT_W-1:0] wcnt, wcnt_nxt;
   logic              mem_stall;
   logic              branch;
   logic              load_use;

   // Memory-stage bypass wins over writeback: it carries the younger value.
   function automatic logic [1:0] fwd_sel(input logic [4:0] rs,
                                          input logic       we_m, input logic [4:0] rd_m,
                                          input logic       we_w, input logic [4:0] rd_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (we_m && (rd_m != 5'd0) && (rd_m == rs))
         sel = 2'b01;
      else if (we_w && (rd_w != 5'd0) && (rd_w == rs))
         sel = 2'b10;
      return sel;
   endfunction

   always_comb begin
      HU_RS1 = fwd_sel(RS1_E, WE_M, RD_M, WE_W, RD_W);
      HU_RS2 = fwd_sel(RS2_E, WE_M, RD_M, WE_W, RD_W);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= RUN;
         wcnt  <= '0;
      end else begin
         state <= state_nxt;
         wcnt  <= wcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      wcnt_nxt  = wcnt;
      mem_stall = 1'b0;
      unique case (state)
         RUN: begin
            if (MEM_REQ && !MEM_ACK) begin
               mem_stall = 1'b1;
               state_nxt = WAIT;
               wcnt_nxt  = WCNT_W'(1);
            end
         end
         WAIT: begin
            if (MEM_ACK) begin
               state_nxt = RUN;
               wcnt_nxt  = '0;
            end else begin
               mem_stall = 1'b1;
               if (wcnt == TIMEOUT_V)
                  state_nxt = ERROR;
               else
                  wcnt_nxt = wcnt + WCNT_W'(1);
            end
         end
         ERROR: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_nxt = RUN;
            wcnt_nxt  = '0;
         end
      endcase
   end

   assign ERR = (state == ERROR);

   // Priority: memory stall, then taken branch, then load-use interlock.
   always_comb begin
      branch   = !mem_stall && PC_R;
      load_use = !mem_stall && !PC_R && MEM_REG_E && (RD_E != 5'd0) &&
                 ((RD_E == RS1_D) || (RD_E == RS2_D));
      STALL_F  = mem_stall || load_use;
      STALL_D  = mem_stall || load_use;
      STALL_E  = mem_stall;
      STALL_M  = mem_stall;
      FLUSH_D  = branch;
      FLUSH_E  = branch || load_use;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         STALL_CNT <= '0;
         FLUSH_CNT <= '0;
      end else if (CNT_CLR) begin
         STALL_CNT <= '0;
         FLUSH_CNT <= '0;
      end else begin
         if (STALL_F && (STALL_CNT != '1))
            STALL_CNT <= STALL_CNT + CNT_W'(1);
         if (FLUSH_E && (FLUSH_CNT != '1))
            FLUSH_CNT <= FLUSH_CNT + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Randomized bench for hazard_controller against a cycle-level behavioural model,
// plus directed cases for forwarding, load-use, memory wait, timeout and saturation.
module tb_hazard_controller;

   localparam int unsigned TO   = 4;
   localparam int unsigned CW   = 8;
   localparam int unsigned CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst;
   logic [4:0]    RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W;
   logic          MEM_REG_E, WE_M, WE_W, PC_R, MEM_REQ, MEM_ACK, CNT_CLR;
   logic [1:0]    HU_RS1, HU_RS2;
   logic          STALL_F, STALL_D, STALL_E, STALL_M, FLUSH_D, FLUSH_E, ERR;
   logic [CW-1:0] STALL_CNT, FLUSH_CNT;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // model: unacknowledged-cycle count of the outstanding access and a sticky error
   bit          m_err;
   bit          m_pend;
   int unsigned m_waited;
   int unsigned m_sc, m_fc;

   hazard_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .RS1_D(RS1_D), .RS2_D(RS2_D), .RS1_E(RS1_E), .RS2_E(RS2_E),
      .RD_E(RD_E), .MEM_REG_E(MEM_REG_E), .RD_M(RD_M), .WE_M(WE_M),
      .RD_W(RD_W), .WE_W(WE_W), .PC_R(PC_R), .MEM_REQ(MEM_REQ),
      .MEM_ACK(MEM_ACK), .CNT_CLR(CNT_CLR),
      .HU_RS1(HU_RS1), .HU_RS2(HU_RS2),
      .STALL_F(STALL_F), .STALL_D(STALL_D), .STALL_E(STALL_E), .STALL_M(STALL_M),
      .FLUSH_D(FLUSH_D), .FLUSH_E(FLUSH_E), .ERR(ERR),
      .STALL_CNT(STALL_CNT), .FLUSH_CNT(FLUSH_CNT)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] m_fwd(input logic [4:0] rs);
      if (WE_M && RD_M != 0 && RD_M == rs) return 2'b01;
      if (WE_W && RD_W != 0 && RD_W == rs) return 2'b10;
      return 2'b00;
   endfunction

   task automatic clear_inputs();
      {RS1_D, RS2_D, RS1_E, RS2_E, RD_E, RD_M, RD_W} = '0;
      {MEM_REG_E, WE_M, WE_W, PC_R, MEM_REQ, MEM_ACK, CNT_CLR} = '0;
   endtask

   task automatic model_reset();
      m_err = 0; m_pend = 0; m_waited = 0; m_sc = 0; m_fc = 0;
   endtask

   // Called just after a negedge with inputs applied; checks, then crosses one posedge.
   task automatic cycle();
      bit stall, br, lu;
      #1;
      stall = m_err || (m_pend ? !MEM_ACK : (MEM_REQ && !MEM_ACK));
      br    = !stall && PC_R;
      lu    = !stall && !PC_R && MEM_REG_E && RD_E != 0 && (RD_E == RS1_D || RD_E == RS2_D);
      check("hu_rs1", HU_RS1, m_fwd(RS1_E));
      check("hu_rs2", HU_RS2, m_fwd(RS2_E));
      check("stall_f", STALL_F, stall || lu);
      check("stall_d", STALL_D, stall || lu);
      check("stall_e", STALL_E, stall);
      check("stall_m", STALL_M, stall);
      check("flush_d", FLUSH_D, br);
      check("flush_e", FLUSH_E, br || lu);
      check("err", ERR, m_err);
      check("stall_cnt", STALL_CNT, m_sc);
      check("flush_cnt", FLUSH_CNT, m_fc);
      @(posedge clk);
      if (CNT_CLR) begin
         m_sc = 0; m_fc = 0;
      end else begin
         if ((stall || lu) && m_sc < CMAX) m_sc++;
         if ((br || lu) && m_fc < CMAX) m_fc++;
      end
      if (!m_err) begin
         if (stall) begin
            m_pend = 1;
            m_waited++;
            if (m_waited > TO) m_err = 1;
         end else begin
            m_pend = 0;
            m_waited = 0;
         end
      end
      @(negedge clk);
   endtask

   // Asynchronous reset pulse asserted between edges, released on a negedge.
   task automatic pulse_reset();
      #2 rst = 1'b0;
      #1;
      check("rst_async_err", ERR, 0);
      check("rst_async_cnt", STALL_CNT, 0);
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      clear_inputs();
      model_reset();
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      // all inputs zero under reset: every output zero
      check("rst_hu1", HU_RS1, 0);
      check("rst_stall", {STALL_F, STALL_D, STALL_E, STALL_M}, 0);
      check("rst_flush", {FLUSH_D, FLUSH_E}, 0);
      check("rst_err", ERR, 0);
      check("rst_cnts", {STALL_CNT, FLUSH_CNT}, 0);
      rst = 1'b1;

      // forwarding selection
      RD_M = 5; WE_M = 1; RD_W = 5; WE_W = 1; RS1_E = 5;
      #1 check("fwd_mem", HU_RS1, 2'b01);
      RD_M = 0;
      #1 check("fwd_wb", HU_RS1, 2'b10);
      RS1_E = 0;
      #1 check("fwd_zero", HU_RS1, 2'b00);
      cycle();
      clear_inputs();

      // load-use on RS2_D
      MEM_REG_E = 1; RD_E = 7; RS2_D = 7;
      #1 check("lu_stall", {STALL_F, STALL_D, FLUSH_E, STALL_E, STALL_M, FLUSH_D}, 6'b111000);
      cycle();
      clear_inputs();
      #1 check("lu_scnt", STALL_CNT, 1);
      check("lu_fcnt", FLUSH_CNT, 1);

      // branch overrides load-use
      MEM_REG_E = 1; RD_E = 7; RS2_D = 7; PC_R = 1;
      #1 check("br_over_lu", {FLUSH_D, FLUSH_E, STALL_F}, 3'b110);
      cycle();
      clear_inputs();

      // memory wait of three cycles
      CNT_CLR = 1;
      cycle();
      CNT_CLR = 0; MEM_REQ = 1;
      for (int i = 0; i < 3; i++) begin
         #1 check("mw_stall", {STALL_F, STALL_D, STALL_E, STALL_M}, 4'hF);
         cycle();
      end
      MEM_ACK = 1;
      #1 check("mw_ack_free", {STALL_F, STALL_M}, 0);
      cycle();
      clear_inputs();
      #1 check("mw_run", {STALL_F, STALL_M}, 0);
      check("mw_scnt", STALL_CNT, 3);
      cycle();

      // timeout with branch held: branch acted on only after the stall clears (via reset)
      MEM_REQ = 1;
      for (int i = 0; i < 5; i++) cycle();
      #1 check("to_err", ERR, 1);
      MEM_ACK = 1; PC_R = 1;
      #1 check("to_late_ack", {STALL_F, STALL_M, FLUSH_D}, 3'b110);
      cycle();
      pulse_reset();
      clear_inputs();
      #1 check("to_cleared", {ERR, STALL_F, STALL_M}, 0);
      cycle();

      // counter saturation and clear-beats-increment
      MEM_REG_E = 1; RD_E = 3; RS1_D = 3;
      for (int i = 0; i < (1 << CW) + 3; i++) cycle();
      #1 check("sat_scnt", STALL_CNT, CMAX);
      check("sat_fcnt", FLUSH_CNT, CMAX);
      CNT_CLR = 1;
      cycle();
      CNT_CLR = 0;
      #1 check("clr_scnt", STALL_CNT, 0);
      check("clr_fcnt", FLUSH_CNT, 0);
      clear_inputs();

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         RS1_D = 5'($urandom_range(0, 3)); RS2_D = 5'($urandom_range(0, 3));
         RS1_E = 5'($urandom_range(0, 3)); RS2_E = 5'($urandom_range(0, 3));
         RD_E  = 5'($urandom_range(0, 3)); RD_M  = 5'($urandom_range(0, 3));
         RD_W  = 5'($urandom_range(0, 3));
         MEM_REG_E = ($urandom_range(0, 1) == 1);
         WE_M      = ($urandom_range(0, 1) == 1);
         WE_W      = ($urandom_range(0, 1) == 1);
         PC_R      = ($urandom_range(0, 4) == 0);
         MEM_REQ   = ($urandom_range(0, 2) == 0);
         MEM_ACK   = ($urandom_range(0, 2) != 0);
         CNT_CLR   = ($urandom_range(0, 49) == 0);
         if (n % 8 == 5 && $urandom_range(0, 1) == 1) MEM_ACK = 0;
         cycle();
         if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
            pulse_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      bad++;
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
